// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 exception/interrupt controller:
// register indices, exception codes and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_t;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int SR_IM_HI    = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_BD    = 31;

  // A victim in a delay slot restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId register file plus the single
// exception/interrupt request line that flushes the pipeline.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h5052_4F43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hwint,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_excCode;
  logic [31:0] r_epc;

  logic        w_intReq;
  logic        w_excReq;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unusedIn;

  assign w_unusedIn = ^{cp0_in[31:16], cp0_in[9:2]};

  assign w_intReq = (|(hwint & r_im)) & r_ie & ~r_exl;
  assign w_excReq = (exc_code_in != 5'd0) & ~r_exl;
  assign req      = w_intReq | w_excReq;
  assign epc_out  = r_epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_excCode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= hwint;
      if (req) begin
        r_exl     <= 1'b1;
        r_bd      <= bd_in;
        r_excCode <= w_intReq ? EXC_INT : exc_code_in;
        r_epc     <= epc_target(vpc, bd_in);
      end else begin
        // eret clears first so a same-cycle mtc0 to SR decides the final EXL.
        if (exl_clr)
          r_exl <= 1'b0;
        if (en && (cp0_addr == CP0_SR)) begin
          r_im  <= cp0_in[SR_IM_HI:SR_IM_LO];
          r_exl <= cp0_in[SR_EXL];
          r_ie  <= cp0_in[SR_IE];
        end
        if (en && (cp0_addr == CP0_EPC))
          r_epc <= cp0_in;
      end
    end
  end

  always_comb begin
    w_sr = '0;
    w_sr[SR_IM_HI:SR_IM_LO] = r_im;
    w_sr[SR_EXL] = r_exl;
    w_sr[SR_IE]  = r_ie;
    w_cause = '0;
    w_cause[CAUSE_BD] = r_bd;
    w_cause[CAUSE_IP_HI:CAUSE_IP_LO] = r_ip;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_excCode;
  end

  always_comb begin
    cp0_out = '0;
    case (cp0_addr)
      CP0_SR:    cp0_out = w_sr;
      CP0_CAUSE: cp0_out = w_cause;
      CP0_EPC:   cp0_out = r_epc;
      CP0_PRID:  cp0_out = PRID;
      default:   cp0_out = '0;
    endcase
  end

endmodule
